read_req_arbiter: RTL and testbench

READ_REQ_ARBITER -- requirements
Module: read_req_arbiter

---
 rtl/read_req_arbiter_if.sv | 32 +++
 rtl/read_req_arbiter.sv | 178 +++++++++++++++++
 tb/tb_read_req_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/read_req_arbiter_if.sv
// AXI read-address / read-data channel bundle used between the
// request arbiter (master) and the memory side (slave).
interface read_req_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic [15:0]       arid_m;
    logic [ADDR_W-1:0] araddr_m;
    logic [7:0]        arlen_m;
    logic [2:0]        arsize_m;
    logic              arvalid_m;
    logic              arready_m;
    logic [15:0]       rid_m;
    logic [511:0]      rdata_m;
    logic [1:0]        rresp_m;
    logic              rlast_m;
    logic              rvalid_m;
    logic              rready_m;

    modport master (
        output arid_m, araddr_m, arlen_m, arsize_m, arvalid_m,
        input  arready_m,
        input  rid_m, rdata_m, rresp_m, rlast_m, rvalid_m,
        output rready_m
    );

    modport slave (
        input  arid_m, araddr_m, arlen_m, arsize_m, arvalid_m,
        output arready_m,
        output rid_m, rdata_m, rresp_m, rlast_m, rvalid_m,
        input  rready_m
    );
endinterface

// File: rtl/read_req_arbiter.sv
// Three-requester AXI read arbiter: one AR in flight at a time,
// per-requester outstanding limits, R beats routed back by rid.
module read_req_arbiter #(
    parameter int MAX_OUT = 4,
    parameter int ADDR_W  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req_valid,
    input  logic [3*ADDR_W-1:0]   req_addr,
    output logic [2:0]            req_ready,
    output logic [2:0]            resp_valid,
    output logic [511:0]          resp_data,
    input  logic [2:0]            resp_ready,
    output logic [2:0]            err,
    output logic                  all_idle,
    read_req_arbiter_if.master    axi
);

    typedef enum logic {IDLE, ISSUE} state_e;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [1:0]        arid_q, arid_d;
    logic              rr_q, rr_d;
    logic [2:0][3:0]   out_q, out_d;
    logic [2:0]        err_q, err_d;
    logic              all_idle_q, all_idle_d;

    logic [2:0] eligible;
    logic [2:0] grant;
    logic       rid_ok;
    logic [1:0] ridx;
    logic       rready;
    logic       r_hs;
    logic       r_dec;
    logic       ar_hs;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            eligible[i] = req_valid[i] && (out_q[i] < MAX_CNT);
        end
    end

    // Requester 2 always wins; 0 and 1 alternate when both are eligible.
    always_comb begin
        grant = 3'b000;
        if (state_q == IDLE) begin
            if (eligible[2]) begin
                grant = 3'b100;
            end else if (eligible[0] && eligible[1]) begin
                grant = rr_q ? 3'b010 : 3'b001;
            end else if (eligible[0]) begin
                grant = 3'b001;
            end else if (eligible[1]) begin
                grant = 3'b010;
            end
        end
    end

    assign req_ready = rst ? 3'b000 : grant;

    assign rid_ok = (axi.rid_m < 16'd3);
    assign ridx   = axi.rid_m[1:0];

    always_comb begin
        resp_valid = 3'b000;
        rready     = 1'b1;
        if (rid_ok) begin
            resp_valid[ridx] = axi.rvalid_m;
            rready           = resp_ready[ridx];
        end
    end

    assign r_hs  = axi.rvalid_m && rready;
    assign r_dec = r_hs && axi.rlast_m && rid_ok;
    assign ar_hs = (state_q == ISSUE) && axi.arready_m;

    always_comb begin
        out_d = out_q;
        err_d = err_q;
        for (int i = 0; i < 3; i++) begin
            logic inc;
            logic dec;
            inc = ar_hs && (arid_q == 2'(i));
            dec = r_dec && (ridx == 2'(i));
            if (inc && !dec) begin
                out_d[i] = out_q[i] + 4'd1;
            end else if (dec && !inc) begin
                if (out_q[i] == 4'd0) begin
                    err_d[i] = 1'b1;
                end else begin
                    out_d[i] = out_q[i] - 4'd1;
                end
            end
        end
        // Unroutable ids poison every requester.
        if (r_hs && !rid_ok) begin
            err_d = 3'b111;
        end
        if (r_hs && rid_ok && (axi.rresp_m != 2'b00)) begin
            err_d[ridx] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        araddr_d = araddr_q;
        arid_d   = arid_q;
        rr_d     = rr_q;
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    grant[2]: begin
                        araddr_d = req_addr[2*ADDR_W +: ADDR_W];
                        arid_d   = 2'd2;
                        state_d  = ISSUE;
                    end
                    grant[1]: begin
                        araddr_d = req_addr[1*ADDR_W +: ADDR_W];
                        arid_d   = 2'd1;
                        rr_d     = 1'b0;
                        state_d  = ISSUE;
                    end
                    grant[0]: begin
                        araddr_d = req_addr[0 +: ADDR_W];
                        arid_d   = 2'd0;
                        rr_d     = 1'b1;
                        state_d  = ISSUE;
                    end
                    default: ;
                endcase
            end
            ISSUE: begin
                if (axi.arready_m) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign all_idle_d = (state_q == IDLE) && (out_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            araddr_q   <= '0;
            arid_q     <= 2'd0;
            rr_q       <= 1'b0;
            out_q      <= '0;
            err_q      <= 3'b000;
            all_idle_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            araddr_q   <= araddr_d;
            arid_q     <= arid_d;
            rr_q       <= rr_d;
            out_q      <= out_d;
            err_q      <= err_d;
            all_idle_q <= all_idle_d;
        end
    end

    assign axi.arvalid_m = (state_q == ISSUE);
    assign axi.araddr_m  = araddr_q;
    assign axi.arid_m    = {14'd0, arid_q};
    assign axi.arlen_m   = 8'd0;
    assign axi.arsize_m  = 3'b011;
    assign axi.rready_m  = rready;

    assign resp_data = axi.rdata_m;
    assign err       = err_q;
    assign all_idle  = all_idle_q;

endmodule

// File: tb/tb_read_req_arbiter.sv
// Directed bench for read_req_arbiter: grants, backpressure,
// routing, error flags and counter corner cases.
module tb_read_req_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_valid;
    logic [191:0]  req_addr;
    logic [2:0]    req_ready;
    logic [2:0]    resp_valid;
    logic [511:0]  resp_data;
    logic [2:0]    resp_ready;
    logic [2:0]    err;
    logic          all_idle;

    int checks   = 0;
    int failures = 0;

    read_req_arbiter_if #(.ADDR_W(64)) axi ();

    read_req_arbiter #(.MAX_OUT(4), .ADDR_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .err        (err),
        .all_idle   (all_idle),
        .axi        (axi.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid     = 3'b000;
        req_addr      = '0;
        resp_ready    = 3'b000;
        axi.arready_m = 1'b0;
        axi.rid_m     = 16'd0;
        axi.rdata_m   = '0;
        axi.rresp_m   = 2'b00;
        axi.rlast_m   = 1'b0;
        axi.rvalid_m  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        req_valid = 3'b111;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b000) begin
            failures++;
            $display("FAIL reset_req_ready got=%b exp=000", req_ready);
        end
        checks++;
        if (axi.arvalid_m !== 1'b0 || axi.araddr_m !== 64'd0 ||
            axi.arid_m !== 16'd0) begin
            failures++;
            $display("FAIL reset_ar got=%b/%h/%h exp=0/0/0",
                     axi.arvalid_m, axi.araddr_m, axi.arid_m);
        end
        checks++;
        if (err !== 3'b000 || all_idle !== 1'b1) begin
            failures++;
            $display("FAIL reset_flags got=%b/%b exp=000/1", err, all_idle);
        end
        checks++;
        if (axi.arlen_m !== 8'd0 || axi.arsize_m !== 3'b011) begin
            failures++;
            $display("FAIL ar_const got=%h/%b exp=00/011",
                     axi.arlen_m, axi.arsize_m);
        end
        tick();
        rst = 1'b0;
        req_valid = 3'b000;
    endtask

    task automatic test_single();
        do_reset();
        req_valid = 3'b001;
        req_addr[63:0] = 64'h1000;
        axi.arready_m = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            failures++;
            $display("FAIL single_grant got=%b exp=001", req_ready);
        end
        tick();
        req_valid = 3'b000;
        @(negedge clk);
        checks++;
        if (axi.arvalid_m !== 1'b1 || axi.araddr_m !== 64'h1000 ||
            axi.arid_m !== 16'd0 || req_ready !== 3'b000) begin
            failures++;
            $display("FAIL single_ar got=%b/%h/%h/%b exp=1/1000/0/000",
                     axi.arvalid_m, axi.araddr_m, axi.arid_m, req_ready);
        end
        tick();
        axi.arready_m = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.arvalid_m !== 1'b0) begin
            failures++;
            $display("FAIL single_ar_drop got=%b exp=0", axi.arvalid_m);
        end
        tick();
        @(negedge clk);
        checks++;
        if (all_idle !== 1'b0) begin
            failures++;
            $display("FAIL single_busy got=%b exp=0", all_idle);
        end
        axi.rvalid_m = 1'b1;
        axi.rid_m    = 16'd0;
        axi.rlast_m  = 1'b1;
        axi.rdata_m  = {16{32'hDEADBEEF}};
        resp_ready   = 3'b001;
        #1;
        checks++;
        if (resp_valid !== 3'b001 || axi.rready_m !== 1'b1 ||
            resp_data !== {16{32'hDEADBEEF}}) begin
            failures++;
            $display("FAIL single_r got=%b/%b exp=001/1",
                     resp_valid, axi.rready_m);
        end
        tick();
        clear_inputs();
        tick();
        @(negedge clk);
        checks++;
        if (all_idle !== 1'b1 || err !== 3'b000) begin
            failures++;
            $display("FAIL single_idle got=%b/%b exp=1/000", all_idle, err);
        end
    endtask

    task automatic test_contention();
        int gseq [16];
        int exp_seq [12];
        int n;
        exp_seq = '{2, 2, 2, 2, 0, 1, 0, 1, 0, 1, 0, 1};
        n = 0;
        do_reset();
        req_valid = 3'b111;
        req_addr  = {64'h300, 64'h200, 64'h100};
        axi.arready_m = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (req_ready != 3'b000 && n < 16) begin
                case (req_ready)
                    3'b001:  gseq[n] = 0;
                    3'b010:  gseq[n] = 1;
                    3'b100:  gseq[n] = 2;
                    default: gseq[n] = 9;
                endcase
                n++;
            end
            tick();
        end
        clear_inputs();
        checks++;
        if (n != 12) begin
            failures++;
            $display("FAIL contention_count got=%0d exp=12", n);
        end
        for (int k = 0; k < 12; k++) begin
            if (k < n) begin
                checks++;
                if (gseq[k] != exp_seq[k]) begin
                    failures++;
                    $display("FAIL contention_order[%0d] got=%0d exp=%0d",
                             k, gseq[k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        do_reset();
        req_valid = 3'b010;
        req_addr[127:64] = 64'hABC0;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010) begin
            failures++;
            $display("FAIL bp_grant got=%b exp=010", req_ready);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            if (axi.arvalid_m !== 1'b1 || axi.araddr_m !== 64'hABC0 ||
                axi.arid_m !== 16'd1 || req_ready !== 3'b000) begin
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold got=%0d bad cycles exp=0", bad);
        end
        tick();
        axi.arready_m = 1'b1;
        req_valid = 3'b000;
        @(negedge clk);
        checks++;
        if (axi.arvalid_m !== 1'b1 || axi.araddr_m !== 64'hABC0) begin
            failures++;
            $display("FAIL bp_release got=%b/%h exp=1/abc0",
                     axi.arvalid_m, axi.araddr_m);
        end
        tick();
        axi.arready_m = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.arvalid_m !== 1'b0 || dut.out_q[1] !== 4'd1) begin
            failures++;
            $display("FAIL bp_single got=%b/%0d exp=0/1",
                     axi.arvalid_m, dut.out_q[1]);
        end
    endtask

    task automatic test_routing();
        axi.rvalid_m = 1'b1;
        axi.rid_m    = 16'd1;
        axi.rlast_m  = 1'b1;
        resp_ready   = 3'b000;
        #1;
        checks++;
        if (resp_valid !== 3'b010 || axi.rready_m !== 1'b0) begin
            failures++;
            $display("FAIL route_stall got=%b/%b exp=010/0",
                     resp_valid, axi.rready_m);
        end
        tick();
        checks++;
        if (dut.out_q[1] !== 4'd1) begin
            failures++;
            $display("FAIL route_hold got=%0d exp=1", dut.out_q[1]);
        end
        resp_ready = 3'b010;
        #1;
        checks++;
        if (resp_valid !== 3'b010 || axi.rready_m !== 1'b1) begin
            failures++;
            $display("FAIL route_go got=%b/%b exp=010/1",
                     resp_valid, axi.rready_m);
        end
        tick();
        clear_inputs();
        checks++;
        if (dut.out_q[1] !== 4'd0 || err !== 3'b000) begin
            failures++;
            $display("FAIL route_dec got=%0d/%b exp=0/000",
                     dut.out_q[1], err);
        end
    endtask

    task automatic test_errors();
        do_reset();
        axi.rvalid_m = 1'b1;
        axi.rid_m    = 16'd2;
        axi.rlast_m  = 1'b0;
        axi.rresp_m  = 2'b10;
        resp_ready   = 3'b100;
        tick();
        clear_inputs();
        tick();
        tick();
        checks++;
        if (err !== 3'b100) begin
            failures++;
            $display("FAIL err_resp got=%b exp=100", err);
        end
        axi.rvalid_m = 1'b1;
        axi.rid_m    = 16'd5;
        #1;
        checks++;
        if (axi.rready_m !== 1'b1 || resp_valid !== 3'b000) begin
            failures++;
            $display("FAIL err_badid got=%b/%b exp=1/000",
                     axi.rready_m, resp_valid);
        end
        tick();
        clear_inputs();
        checks++;
        if (err !== 3'b111) begin
            failures++;
            $display("FAIL err_all got=%b exp=111", err);
        end
        do_reset();
        checks++;
        if (err !== 3'b000) begin
            failures++;
            $display("FAIL err_clear got=%b exp=000", err);
        end
        axi.rvalid_m = 1'b1;
        axi.rid_m    = 16'd0;
        axi.rlast_m  = 1'b1;
        resp_ready   = 3'b001;
        tick();
        clear_inputs();
        checks++;
        if (err !== 3'b001 || dut.out_q[0] !== 4'd0) begin
            failures++;
            $display("FAIL err_underflow got=%b/%0d exp=001/0",
                     err, dut.out_q[0]);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_valid = 3'b001;
        req_addr[63:0] = 64'h40;
        axi.arready_m = 1'b1;
        tick();
        req_valid = 3'b000;
        tick();
        req_valid = 3'b001;
        axi.arready_m = 1'b0;
        tick();
        req_valid     = 3'b000;
        axi.arready_m = 1'b1;
        axi.rvalid_m  = 1'b1;
        axi.rid_m     = 16'd0;
        axi.rlast_m   = 1'b1;
        resp_ready    = 3'b001;
        #1;
        checks++;
        if (axi.arvalid_m !== 1'b1 || axi.rready_m !== 1'b1) begin
            failures++;
            $display("FAIL simul_hs got=%b/%b exp=1/1",
                     axi.arvalid_m, axi.rready_m);
        end
        tick();
        clear_inputs();
        checks++;
        if (dut.out_q[0] !== 4'd1 || err !== 3'b000) begin
            failures++;
            $display("FAIL simul_cnt got=%0d/%b exp=1/000",
                     dut.out_q[0], err);
        end
    endtask

    task automatic test_reset_issue();
        do_reset();
        req_valid = 3'b100;
        req_addr[191:128] = 64'h7700;
        tick();
        req_valid = 3'b000;
        @(negedge clk);
        checks++;
        if (axi.arvalid_m !== 1'b1 || axi.arid_m !== 16'd2) begin
            failures++;
            $display("FAIL rstiss_pre got=%b/%h exp=1/2",
                     axi.arvalid_m, axi.arid_m);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (axi.arvalid_m !== 1'b0 || axi.araddr_m !== 64'd0) begin
            failures++;
            $display("FAIL rstiss_drop got=%b/%h exp=0/0",
                     axi.arvalid_m, axi.araddr_m);
        end
        tick();
        axi.rvalid_m = 1'b1;
        axi.rid_m    = 16'd2;
        axi.rlast_m  = 1'b1;
        resp_ready   = 3'b100;
        #1;
        checks++;
        if (resp_valid !== 3'b100 || axi.rready_m !== 1'b1) begin
            failures++;
            $display("FAIL rstiss_route got=%b/%b exp=100/1",
                     resp_valid, axi.rready_m);
        end
        tick();
        clear_inputs();
        checks++;
        if (dut.out_q[2] !== 4'd0 || err !== 3'b100) begin
            failures++;
            $display("FAIL rstiss_floor got=%0d/%b exp=0/100",
                     dut.out_q[2], err);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_routing();
        test_errors();
        test_simultaneous();
        test_reset_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
